// File: rtl/i2c_slave.sv
`default_nettype none
// ============================================================================
// Module   : i2c_slave
// Purpose  : 7-bit-address I2C slave with byte-wide write/read interface.
//            SCL is only observed and is never stretched. SDA is open-drain:
//            the slave either pulls it low or leaves it high-Z.
// Ports    : clk       - system clock, all logic on the rising edge
//            rst       - synchronous active-high reset
//            i2c_scl   - I2C clock from the master
//            i2c_sda   - I2C data (inout, open-drain)
//            tx_data   - byte returned to the master on a read
//            tx_req    - one-clk pulse when tx_data is loaded into the shifter
//            rx_data   - last byte written by the master
//            rx_valid  - one-clk pulse when rx_data updates
//            busy      - high whenever the FSM is not idle
// Revision : 1.0 - initial release
// ============================================================================
module i2c_slave #(
  parameter logic [6:0] SLAVE_ADDR  = 7'h50,
  parameter int         SYNC_STAGES = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       i2c_scl,
  inout  wire        i2c_sda,
  input  logic [7:0] tx_data,
  output logic       tx_req,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  output logic       busy
);

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_ADDR      = 3'd1,
    S_ADDR_ACK  = 3'd2,
    S_WRITE     = 3'd3,
    S_WRITE_ACK = 3'd4,
    S_READ      = 3'd5,
    S_READ_ACK  = 3'd6
  } state_t;

  logic [SYNC_STAGES-1:0] scl_sync_q, scl_sync_d;
  logic [SYNC_STAGES-1:0] sda_sync_q, sda_sync_d;
  logic                   scl_hist_q, scl_hist_d;
  logic                   sda_hist_q, sda_hist_d;

  state_t     state_q, state_d;
  logic [7:0] shift_q, shift_d;
  logic [2:0] cnt_q, cnt_d;
  logic       rw_q, rw_d;
  logic       oe_q, oe_d;
  logic       reload_q, reload_d;
  logic [7:0] rx_data_q, rx_data_d;
  logic       rx_valid_q, rx_valid_d;
  logic       tx_req_q, tx_req_d;

  logic       scl_s, sda_s;
  logic       start_det, stop_det, scl_rise, scl_fall;
  logic [7:0] shift_in;
  logic       load_tx;

  assign scl_s = scl_sync_q[SYNC_STAGES-1];
  assign sda_s = sda_sync_q[SYNC_STAGES-1];

  assign start_det = scl_s & scl_hist_q & sda_hist_q & ~sda_s;
  assign stop_det  = scl_s & scl_hist_q & ~sda_hist_q & sda_s;
  assign scl_rise  = scl_s & ~scl_hist_q;
  assign scl_fall  = ~scl_s & scl_hist_q;
  assign shift_in  = {shift_q[6:0], sda_s};

  // Open-drain output straight from a flop so SDA never glitches low.
  assign i2c_sda  = oe_q ? 1'b0 : 1'bz;
  assign rx_data  = rx_data_q;
  assign rx_valid = rx_valid_q;
  assign tx_req   = tx_req_q;
  assign busy     = (state_q != S_IDLE);

  always_comb begin
    scl_sync_d = {scl_sync_q[SYNC_STAGES-2:0], i2c_scl};
    sda_sync_d = {sda_sync_q[SYNC_STAGES-2:0], i2c_sda};
    scl_hist_d = scl_s;
    sda_hist_d = sda_s;
  end

  always_comb begin
    state_d    = state_q;
    shift_d    = shift_q;
    cnt_d      = cnt_q;
    rw_d       = rw_q;
    oe_d       = oe_q;
    reload_d   = reload_q;
    rx_data_d  = rx_data_q;
    rx_valid_d = 1'b0;
    tx_req_d   = 1'b0;
    load_tx    = 1'b0;

    if (start_det) begin
      state_d  = S_ADDR;
      cnt_d    = 3'd0;
      oe_d     = 1'b0;
      reload_d = 1'b0;
    end else if (stop_det) begin
      state_d  = S_IDLE;
      oe_d     = 1'b0;
      reload_d = 1'b0;
    end else begin
      case (state_q)
        S_ADDR: begin
          if (scl_rise) begin
            shift_d = shift_in;
            cnt_d   = cnt_q + 3'd1;
            if (cnt_q == 3'd7) begin
              // shift_in[7:1] is shift_q[6:0]; shift_in[0] is the R/W bit.
              if (shift_q[6:0] == SLAVE_ADDR) begin
                rw_d    = sda_s;
                state_d = S_ADDR_ACK;
              end else begin
                state_d = S_IDLE;
              end
            end
          end
        end
        S_ADDR_ACK, S_WRITE_ACK: begin
          // First fall drives ACK low; the pull-down itself marks that the
          // second fall ends the ACK slot.
          if (scl_fall) begin
            if (!oe_q) begin
              oe_d = 1'b1;
            end else begin
              oe_d  = 1'b0;
              cnt_d = 3'd0;
              if ((state_q == S_ADDR_ACK) && rw_q) begin
                state_d = S_READ;
                load_tx = 1'b1;
              end else begin
                state_d = S_WRITE;
              end
            end
          end
        end
        S_WRITE: begin
          if (scl_rise) begin
            shift_d = shift_in;
            cnt_d   = cnt_q + 3'd1;
            if (cnt_q == 3'd7) begin
              rx_data_d  = shift_in;
              rx_valid_d = 1'b1;
              state_d    = S_WRITE_ACK;
            end
          end
        end
        S_READ: begin
          if (scl_fall) begin
            if (reload_q) begin
              reload_d = 1'b0;
              load_tx  = 1'b1;
            end else if (cnt_q == 3'd7) begin
              oe_d    = 1'b0;
              cnt_d   = 3'd0;
              state_d = S_READ_ACK;
            end else begin
              shift_d = {shift_q[6:0], 1'b0};
              oe_d    = ~shift_q[6];
              cnt_d   = cnt_q + 3'd1;
            end
          end
        end
        S_READ_ACK: begin
          if (scl_rise) begin
            if (!sda_s) begin
              state_d  = S_READ;
              reload_d = 1'b1;
            end else begin
              state_d = S_IDLE;
            end
          end
        end
        default: begin
        end
      endcase
    end

    if (load_tx) begin
      shift_d  = tx_data;
      oe_d     = ~tx_data[7];
      tx_req_d = 1'b1;
      cnt_d    = 3'd0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      scl_sync_q <= '1;
      sda_sync_q <= '1;
      scl_hist_q <= 1'b1;
      sda_hist_q <= 1'b1;
      state_q    <= S_IDLE;
      shift_q    <= 8'h00;
      cnt_q      <= 3'd0;
      rw_q       <= 1'b0;
      oe_q       <= 1'b0;
      reload_q   <= 1'b0;
      rx_data_q  <= 8'h00;
      rx_valid_q <= 1'b0;
      tx_req_q   <= 1'b0;
    end else begin
      scl_sync_q <= scl_sync_d;
      sda_sync_q <= sda_sync_d;
      scl_hist_q <= scl_hist_d;
      sda_hist_q <= sda_hist_d;
      state_q    <= state_d;
      shift_q    <= shift_d;
      cnt_q      <= cnt_d;
      rw_q       <= rw_d;
      oe_q       <= oe_d;
      reload_q   <= reload_d;
      rx_data_q  <= rx_data_d;
      rx_valid_q <= rx_valid_d;
      tx_req_q   <= tx_req_d;
    end
  end

endmodule
`default_nettype wire
